// File: rtl/dpd_pkg.sv
// Shared types and helpers for the multi-channel phase/frequency detector.
// Fixed-point values carry FRAC_BITS fractional bits unless noted otherwise.
package dpd_pkg;

  localparam int FRAC_BITS = 10;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_HOLD,
    MODE_OVR,
    MODE_OPEN
  } dpd_mode_e;

  // openLoop beats overwrite beats hold.
  function automatic dpd_mode_e mode_sel(input logic open_loop, input logic ovr,
                                         input logic hld);
    if (open_loop) return MODE_OPEN;
    if (ovr) return MODE_OVR;
    if (hld) return MODE_HOLD;
    return MODE_RUN;
  endfunction

  function automatic logic signed [63:0] sat_max(input int aw);
    return (64'sd1 <<< (aw - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] round_half_away(input logic signed [63:0] v,
                                                         input int sh);
    logic [63:0] mag;
    logic [63:0] r;
    if (sh <= 0) return v;
    mag = v[63] ? 64'(-v) : 64'(v);
    r = (mag + (64'd1 << (sh - 1))) >> sh;
    return v[63] ? -$signed(r) : $signed(r);
  endfunction

endpackage

// File: rtl/dpd_chan_err.sv
// One channel of the detector: edge difference, period wrap, frequency error
// against P*frac and rounding back to FRAC_BITS. Purely combinational.
module dpd_chan_err
  import dpd_pkg::*;
#(
  parameter int TW = 16,
  parameter int FW = 16
) (
  input  logic [TW-1:0]        edge_ts,
  input  logic [TW-1:0]        prev,
  input  logic [TW-1:0]        period,
  input  logic [FW-1:0]        frac,
  input  logic                 inv,
  output logic [TW-1:0]        finst,
  output logic signed [TW-1:0] ferror
);

  localparam int EW = TW + FW + 2;

  logic signed [TW:0]   diff;
  logic signed [TW:0]   per_s;
  logic signed [TW:0]   finst_w;
  logic [TW+FW-1:0]     tgt;
  logic signed [EW-1:0] e_raw;
  logic signed [EW-1:0] e_wrap;
  logic signed [EW-1:0] half;
  logic signed [EW-1:0] full;
  logic signed [63:0]   e_rnd;

  assign per_s = $signed({1'b0, period});
  assign diff  = inv ? $signed({1'b0, edge_ts}) - $signed({1'b0, prev})
                     : $signed({1'b0, prev}) - $signed({1'b0, edge_ts});

  always_comb begin
    finst_w = diff;
    if (diff < 0)          finst_w = diff + per_s;
    else if (diff > per_s) finst_w = diff - per_s;
  end

  assign finst = finst_w[TW-1:0];

  // Target advance keeps all FW fraction bits so the error is exact before rounding.
  assign tgt   = (TW+FW)'(period) * (TW+FW)'(frac);
  assign e_raw = $signed({2'b00, finst, {FW{1'b0}}}) - $signed({2'b00, tgt});
  assign half  = $signed({3'b000, period, {(FW-1){1'b0}}});
  assign full  = $signed({2'b00, period, {FW{1'b0}}});

  always_comb begin
    e_wrap = e_raw;
    if (e_raw >= half)       e_wrap = e_raw - full;
    else if (e_raw < -half)  e_wrap = e_raw + full;
  end

  assign e_rnd  = round_half_away({{(64-EW){e_wrap[EW-1]}}, e_wrap}, FW);
  assign ferror = e_rnd[TW-1:0];

endmodule

// File: rtl/dpd_multi.sv
// N-channel digital phase/frequency detector: per-channel error (stage 1),
// masked average integrated into a saturating loop-filter input (stage 2).
module dpd_multi
  import dpd_pkg::*;
#(
  parameter int NCH      = 2,
  parameter int TW       = 16,
  parameter int FW       = 16,
  parameter int AW       = 19,
  parameter int WARMUP   = 2,
  parameter int LOCK_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 rst_cnt,
  input  logic [NCH*TW-1:0]    edges,
  input  logic                 edges_valid,
  input  logic [TW-1:0]        eff_period,
  input  logic [FW-1:0]        frac,
  input  logic                 inv_dpd,
  input  logic [NCH-1:0]       ch_en,
  input  logic                 openLoop,
  input  logic                 ovr_en,
  input  logic [AW-1:0]        overwrite_dpd,
  input  logic                 hold,
  input  logic [TW-1:0]        lock_thr,
  output logic [NCH*TW-1:0]    finst,
  output logic [NCH*TW-1:0]    ferror,
  output logic [AW-1:0]        dpd_out,
  output logic                 dpd_valid,
  output logic                 warm,
  output logic                 locked
);

  localparam int LG     = $clog2(NCH);
  localparam int SW     = TW + LG;
  localparam int LCW    = $clog2(LOCK_CNT + 1);
  localparam int STAGES = 1;

  logic [NCH-1:0][TW-1:0] edges_a;
  logic [NCH-1:0][TW-1:0] prev_edges;
  logic [NCH-1:0][TW-1:0] finst_c;
  logic [NCH-1:0][TW-1:0] ferror_c;
  logic [NCH-1:0][TW-1:0] finst_r;
  logic [NCH-1:0][TW-1:0] ferror_r;

  logic [3:0]             warm_cnt;
  logic [STAGES:0]        vld_pipe;
  logic signed [AW-1:0]   dpd_r;
  logic [LCW-1:0]         lock_cnt;
  logic                   locked_r;

  assign edges_a = edges;

  dpd_chan_err #(.TW(TW), .FW(FW)) u_ch [NCH-1:0] (
    .edge_ts (edges_a),
    .prev    (prev_edges),
    .period  (eff_period),
    .frac    (frac),
    .inv     (inv_dpd),
    .finst   (finst_c),
    .ferror  (ferror_c)
  );

  // Stage 2 datapath: masked sum, rounded average, saturating accumulate.
  logic signed [SW-1:0] sum;
  logic signed [63:0]   avg64;
  logic signed [63:0]   acc64;
  logic signed [63:0]   smax;
  logic signed [AW-1:0] dpd_sat;
  logic signed [TW:0]   fx;
  logic [TW:0]          mag;
  logic                 lock_ok;
  logic [LCW-1:0]       lock_nxt;
  dpd_mode_e            mode;

  always_comb begin
    sum = '0;
    for (int i = 0; i < NCH; i++)
      if (ch_en[i]) sum = sum + SW'($signed(ferror_r[i]));
  end

  assign avg64 = round_half_away(64'(sum), LG);
  assign acc64 = 64'(dpd_r) + avg64;
  assign smax  = sat_max(AW);

  always_comb begin
    dpd_sat = acc64[AW-1:0];
    if (acc64 > smax)       dpd_sat = smax[AW-1:0];
    else if (acc64 < -smax) dpd_sat = -smax[AW-1:0];
  end

  // An empty mask never counts as in-lock.
  always_comb begin
    fx      = '0;
    mag     = '0;
    lock_ok = (ch_en != '0) && !openLoop;
    for (int i = 0; i < NCH; i++) begin
      fx  = (TW+1)'($signed(ferror_r[i]));
      mag = fx[TW] ? -fx : fx;
      if (ch_en[i] && (mag > {1'b0, lock_thr})) lock_ok = 1'b0;
    end
  end

  assign lock_nxt = (lock_cnt == LCW'(LOCK_CNT)) ? lock_cnt : lock_cnt + 1'b1;
  assign mode     = mode_sel(openLoop, ovr_en, hold);

  always_ff @(posedge clk) begin
    if (!rst_l || rst_cnt) begin
      prev_edges <= '0;
      finst_r    <= '0;
      ferror_r   <= '0;
      warm_cnt   <= 4'(WARMUP);
      vld_pipe   <= '0;
      dpd_r      <= '0;
      lock_cnt   <= '0;
      locked_r   <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:0], 1'b0};
      if (edges_valid) begin
        prev_edges <= edges_a;
        finst_r    <= finst_c;
        ferror_r   <= ferror_c;
        if (warm_cnt != '0) warm_cnt <= warm_cnt - 1'b1;
        else                vld_pipe[0] <= 1'b1;
      end
      if (vld_pipe[0]) begin
        case (mode)
          MODE_OPEN: dpd_r <= '0;
          MODE_OVR:  dpd_r <= $signed(overwrite_dpd);
          MODE_HOLD: dpd_r <= dpd_r;
          default:   dpd_r <= dpd_sat;
        endcase
        if (lock_ok) begin
          lock_cnt <= lock_nxt;
          locked_r <= (lock_nxt == LCW'(LOCK_CNT));
        end else begin
          lock_cnt <= '0;
          locked_r <= 1'b0;
        end
      end
    end
  end

  assign finst     = finst_r;
  assign ferror    = ferror_r;
  assign dpd_out   = dpd_r;
  assign dpd_valid = vld_pipe[STAGES];
  assign warm      = (warm_cnt != '0);
  assign locked    = locked_r;

endmodule

// File: tb/tb_dpd_multi.sv
// Directed + randomized bench for dpd_multi against an arithmetic reference model.
module tb_dpd_multi;

  localparam int NCH = 2, TW = 16, FW = 16, AW = 19;
  localparam longint SMAX = 262143;

  logic              clk = 0;
  logic              rst_l, rst_cnt;
  logic [NCH*TW-1:0] edges;
  logic              edges_valid;
  logic [TW-1:0]     eff_period;
  logic [FW-1:0]     frac;
  logic              inv_dpd;
  logic [NCH-1:0]    ch_en;
  logic              openLoop, ovr_en, hold;
  logic [AW-1:0]     overwrite_dpd;
  logic [TW-1:0]     lock_thr;
  logic [NCH*TW-1:0] finst, ferror;
  logic [AW-1:0]     dpd_out;
  logic              dpd_valid, warm, locked;

  dpd_multi #(.NCH(NCH), .TW(TW), .FW(FW), .AW(AW), .WARMUP(2), .LOCK_CNT(16)) dut (
    .clk(clk), .rst_l(rst_l), .rst_cnt(rst_cnt), .edges(edges), .edges_valid(edges_valid),
    .eff_period(eff_period), .frac(frac), .inv_dpd(inv_dpd), .ch_en(ch_en),
    .openLoop(openLoop), .ovr_en(ovr_en), .overwrite_dpd(overwrite_dpd), .hold(hold),
    .lock_thr(lock_thr), .finst(finst), .ferror(ferror), .dpd_out(dpd_out),
    .dpd_valid(dpd_valid), .warm(warm), .locked(locked)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  longint m_prev[NCH], m_fe[NCH], ph[NCH];
  longint m_warm, m_dpd, m_lcnt, m_locked;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint rha(input longint v, input longint d);
    if (v >= 0) return (v + d / 2) / d;
    return -((-v + d / 2) / d);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin m_prev[c] = 0; m_fe[c] = 0; end
    m_warm = 2; m_dpd = 0; m_lcnt = 0; m_locked = 0;
  endtask

  // Expected per-channel result of the sample currently on `edges`.
  task automatic model_s1(output logic trig);
    longint p, d, fi, e, r, eg;
    p = longint'(eff_period);
    for (int c = 0; c < NCH; c++) begin
      eg = longint'(edges[c*TW +: TW]);
      d  = inv_dpd ? eg - m_prev[c] : m_prev[c] - eg;
      if (d < 0)      fi = d + p;
      else if (d > p) fi = d - p;
      else            fi = d;
      fi = fi & 64'hFFFF;
      e  = fi * 65536 - p * longint'(frac);
      if (e >= p * 32768)       e = e - p * 65536;
      else if (e < -p * 32768)  e = e + p * 65536;
      r = rha(e, 65536) & 64'hFFFF;
      if (r >= 32768) r = r - 65536;
      chk($sformatf("finst%0d", c), finst[c*TW +: TW], fi);
      chk($sformatf("ferror%0d", c), $signed(ferror[c*TW +: TW]), r);
      m_fe[c]   = r;
      m_prev[c] = eg;
    end
    trig = (m_warm == 0);
    if (!trig) m_warm--;
    chk("warm", warm, m_warm != 0);
  endtask

  task automatic model_s2();
    longint s, a, mg;
    logic ok;
    s  = 0;
    ok = (ch_en != 0) && !openLoop;
    for (int c = 0; c < NCH; c++) if (ch_en[c]) begin
      s  = s + m_fe[c];
      mg = (m_fe[c] < 0) ? -m_fe[c] : m_fe[c];
      if (mg > longint'(lock_thr)) ok = 0;
    end
    a = rha(s, NCH);
    if (openLoop)    m_dpd = 0;
    else if (ovr_en) m_dpd = longint'($signed(overwrite_dpd));
    else if (!hold) begin
      m_dpd = m_dpd + a;
      if (m_dpd > SMAX)  m_dpd = SMAX;
      if (m_dpd < -SMAX) m_dpd = -SMAX;
    end
    if (ok) begin
      if (m_lcnt < 16) m_lcnt++;
      m_locked = (m_lcnt == 16);
    end else begin
      m_lcnt = 0; m_locked = 0;
    end
    chk("dpd_out", $signed(dpd_out), m_dpd);
    chk("locked", locked, m_locked);
  endtask

  task automatic step(input logic [TW-1:0] e0, input logic [TW-1:0] e1);
    logic trig;
    edges = {e1, e0}; edges_valid = 1;
    @(posedge clk); #1; edges_valid = 0;
    model_s1(trig);
    chk("dv_idle", dpd_valid, 0);
    @(posedge clk); #1;
    chk("dv", dpd_valid, trig);
    if (trig) model_s2();
  endtask

  // Advance each channel's phase by a per-channel amount, modulo the period.
  task automatic adv(input longint a0, input longint a1, input int n);
    for (int k = 0; k < n; k++) begin
      ph[0] = (ph[0] + a0) % longint'(eff_period);
      ph[1] = (ph[1] + a1) % longint'(eff_period);
      step(TW'(ph[0]), TW'(ph[1]));
    end
  endtask

  initial begin
    logic trig, pend;
    rst_l = 0; rst_cnt = 0; edges = '0; edges_valid = 0;
    eff_period = 16'h2800; frac = 16'h8000; inv_dpd = 1; ch_en = 2'b11;
    openLoop = 0; ovr_en = 0; hold = 0; overwrite_dpd = '0; lock_thr = '0;
    ph[0] = 0; ph[1] = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dpd", dpd_out, 0);
    chk("rst_dv", dpd_valid, 0);
    chk("rst_warm", warm, 1);
    chk("rst_locked", locked, 0);
    chk("rst_finst", finst, 0);
    chk("rst_ferror", ferror, 0);
    rst_l = 1;

    // warm-up then zero error, then constant +0x100 error
    adv(64'h1400, 64'h1400, 5);
    adv(64'h1500, 64'h1500, 4);

    // period wrap: prev 0x2700 -> 0x1300
    step(16'h2700, 16'h2700);
    step(16'h1300, 16'h1300);
    ph[0] = 16'h1300; ph[1] = 16'h1300;

    // overwrite then positive saturation
    overwrite_dpd = 19'(262100); ovr_en = 1;
    adv(64'h1500, 64'h1500, 1);
    ovr_en = 0;
    adv(64'h1500, 64'h1500, 3);
    // negative mirror
    overwrite_dpd = 19'(-262100); ovr_en = 1;
    adv(64'h1300, 64'h1300, 1);
    ovr_en = 0;
    adv(64'h1300, 64'h1300, 3);

    // hold, open loop, channel mask, empty mask
    hold = 1;     adv(64'h1500, 64'h1500, 3); hold = 0;
    openLoop = 1; adv(64'h1500, 64'h1500, 2); openLoop = 0;
    ch_en = 2'b01; adv(64'h1500, 64'h1700, 3);
    ch_en = 2'b00; adv(64'h1500, 64'h1500, 2);
    ch_en = 2'b11;

    // lock acquisition and loss
    lock_thr = 16'h20;
    adv(64'h1410, 64'h1410, 17);
    adv(64'h1440, 64'h1440, 1);
    adv(64'h13F0, 64'h1410, 3);

    // back-to-back random samples at full rate
    pend = 0;
    for (int k = 0; k < 40; k++) begin
      edges = {16'($urandom_range(0, 16'h27FF)), 16'($urandom_range(0, 16'h27FF))};
      edges_valid = 1;
      @(posedge clk); #1;
      chk("b2b_dv", dpd_valid, pend);
      if (pend) model_s2();
      model_s1(trig);
      pend = trig;
    end
    edges_valid = 0;
    @(posedge clk); #1;
    chk("b2b_dv_tail", dpd_valid, pend);
    if (pend) model_s2();

    // randomized configuration and edges, one sample at a time
    for (int k = 0; k < 30; k++) begin
      eff_period    = 16'($urandom_range(16'h0400, 16'h7FFF));
      frac          = 16'($urandom);
      inv_dpd       = 1'($urandom);
      ch_en         = 2'($urandom_range(1, 3));
      openLoop      = ($urandom_range(0, 7) == 0);
      hold          = ($urandom_range(0, 7) == 0);
      ovr_en        = ($urandom_range(0, 9) == 0);
      overwrite_dpd = 19'($urandom);
      lock_thr      = 16'($urandom_range(0, 16'h1000));
      step(16'($urandom), 16'($urandom));
    end
    eff_period = 16'h2800; frac = 16'h8000; inv_dpd = 1; ch_en = 2'b11;
    openLoop = 0; hold = 0; ovr_en = 0;

    // restart with a stage-2 update pending
    ph[0] = 0; ph[1] = 0;
    adv(64'h1500, 64'h1500, 2);
    edges = {16'h1500, 16'h1500}; edges_valid = 1;
    @(posedge clk); #1; edges_valid = 0;
    model_s1(trig);
    chk("rc_pending", trig, 1);
    rst_cnt = 1;
    @(posedge clk); #1; rst_cnt = 0;
    model_reset();
    chk("rc_dv", dpd_valid, 0);
    chk("rc_dpd", dpd_out, 0);
    chk("rc_warm", warm, 1);
    chk("rc_locked", locked, 0);
    chk("rc_ferror", ferror, 0);
    @(posedge clk); #1;
    chk("rc_dv2", dpd_valid, 0);
    ph[0] = 0; ph[1] = 0;
    adv(64'h1500, 64'h1500, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dpd_multi.md
Name: dpd_multi

Overview:
- Parametrised N-channel digital phase/frequency detector for the DPLL loop.
- Per reference sample, each channel's edge timestamp is differenced against its previous value and wrapped into one effective period. The result is compared with the expected fractional advance (frac x eff_period) to give a signed frequency error per channel.
- Errors from active channels are averaged and integrated into a saturating loop-filter input (dpd_out).
- Adds over the previous generation: valid handshake, channel mask, parametric warm-up, hold mode and lock detection.

Parameters:
- NCH, 2, channel count; must be a power of 2, range 1..8.
- TW, 16, timestamp/period width (TW-10 integer bits, 10 fractional bits).
- FW, 16, width of the frac input (all fractional bits).
- AW, 19, width of the dpd_out accumulator (signed).
- WARMUP, 2, number of valid samples discarded after any restart; range 1..15.
- LOCK_CNT, 16, consecutive in-threshold updates required to assert locked.

Ports:
- clk, in, 1, clock.
- rst_l, in, 1, reset; synchronous, active-low.
- rst_cnt, in, 1, synchronous restart. Same effect as reset except parameters-held state; see priority.
- edges, in, NCH*TW, packed timestamps; channel i occupies [i*TW +: TW].
- edges_valid, in, 1, new sample present this cycle.
- eff_period, in, TW, effective period P; must be nonzero, static while running.
- frac, in, FW, unsigned fractional frequency word.
- inv_dpd, in, 1, 1: diff = edges - prev; 0: diff = prev - edges.
- ch_en, in, NCH, per-channel enable mask.
- openLoop, in, 1, forces dpd_out to 0.
- ovr_en, in, 1, load overwrite_dpd on the next update.
- overwrite_dpd, in, AW, signed overwrite value.
- hold, in, 1, freezes dpd_out.
- lock_thr, in, TW, unsigned error-magnitude threshold for lock.
- finst, out, NCH*TW, registered instantaneous advance per channel.
- ferror, out, NCH*TW, registered signed error per channel.
- dpd_out, out, AW, signed integrated detector output.
- dpd_valid, out, 1, one-cycle pulse when dpd_out is updated.
- warm, out, 1, high while the warm-up count is nonzero.
- locked, out, 1, lock indication.

Behaviour:
- Reset (rst_l=0) or rst_cnt=1, both sampled at the clock edge, set:
  - all outputs to 0;
  - prev_edges to 0;
  - warm-up count to WARMUP, so warm=1;
  - internal lock count to 0.
- rst_l has priority over rst_cnt.
- Stage 1, on a cycle with edges_valid=1:
  - diff_i = TW+1-bit signed difference, direction selected by inv_dpd.
  - finst_i = diff_i + P if diff_i < 0; else diff_i - P if diff_i > P; else diff_i.
  - Target T = P*frac, kept at TW+FW bits (full precision).
  - e_i = finst_i scaled to the same precision, minus T.
  - Wrap e_i into [-P/2, P/2): subtract P if e_i >= P/2; add P if e_i < -P/2.
  - Round to 10 fractional bits, half away from zero, giving ferror_i (signed TW).
  - Register finst and ferror; set prev_edges <= edges for all channels (masked channels included).
  - If the warm-up count > 0: decrement it; no stage-2 trigger.
  - Otherwise raise the stage-2 strobe for the next cycle.
- Stage 2 (the cycle after the strobe):
  - S = sum over i of (ch_en[i] ? ferror_i : 0), width TW+log2(NCH) signed.
  - A = S >> log2(NCH), rounded half away from zero.
  - dpd_out update priority, highest first: openLoop -> 0; ovr_en -> overwrite_dpd; hold -> unchanged; else dpd_out + A.
  - The sum dpd_out + A saturates to ±(2^(AW-1)-1); no wrap-around.
  - dpd_valid=1 for exactly one cycle after every stage-2 update, in all modes.
- Latency: edges_valid to dpd_valid/dpd_out is 2 cycles. Back-to-back edges_valid every cycle is supported at full throughput.
- Lock (evaluated at each stage 2):
  - If every enabled channel has |ferror_i| <= lock_thr and openLoop=0: lock count increments, saturating at LOCK_CNT. locked = (count == LOCK_CNT).
  - Otherwise the count and locked clear to 0.
  - ch_en = 0 means the condition is not met.
- ch_en changes take effect on the next stage 2. A masked channel still updates its finst/ferror/prev registers.
- Restart mid-operation (rst_cnt while the strobe is pending): the strobe is cancelled; no dpd_valid is produced.

Decomposition:
- Shared package dpd_pkg holds:
  - mode priority encoding;
  - saturation limit function (AW);
  - round-half-away helper function;
  - fixed-point fraction constant FRAC_BITS=10.
- Sub-module dpd_chan_err, instanced NCH times: purely combinational diff/wrap/error/round for one channel. All registers live in the top level.

Test Plan:
- Reset/warm-up: NCH=2, P=0x2800, frac=0x8000, inv_dpd=1, edges advance +0x1400 per sample -> warm=1 for the first 2 samples, no dpd_valid. Then ferror=0, dpd_out stays 0, dpd_valid 2 cycles after each sample.
- Positive error: as above, edges advance +0x1500 -> ferror_i=0x0100, A=0x100, dpd_out = 256, 512, 768, ...
- Period wrap: prev=0x2700, edges=0x1300, inv_dpd=1 -> finst=0x1400, ferror=0.
- Saturation/overwrite: ovr_en pulse with overwrite_dpd=262100, then A=+0x100 per update -> dpd_out 262100 -> 262143, then holds at 262143. Negative mirror saturates at -262143.
- Modes: hold=1 -> dpd_out frozen while dpd_valid still pulses. openLoop=1 -> dpd_out=0 and locked=0. ch_en=2'b01 with ferror0=0x100, ferror1=0x300 -> A=0x080.
- Lock/restart: lock_thr=0x20 with |ferror|=0x10 for 16 updates -> locked=1 on the 16th; one error of 0x40 -> locked=0. rst_cnt pulse mid-stream -> outputs 0, warm=1, pending dpd_valid suppressed.
